// File: rtl/axil_periph_bridge.sv
// AXI4-Lite 1-to-N address decoder: routes each master transaction to one slave window
// with a local offset address, and answers DECERR itself for unmapped addresses.
module axil_periph_bridge #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int                    NUM_SLAVES      = 4,
    parameter int                    SLAVE_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h1000_0000
) (
    input  logic                             clk,
    input  logic                             rst,
    // master write address / data / response
    input  logic [ADDR_WIDTH-1:0]            s_awaddr,
    input  logic [2:0]                       s_awprot,
    input  logic                             s_awvalid,
    output logic                             s_awready,
    input  logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [STRB_WIDTH-1:0]            s_wstrb,
    input  logic                             s_wvalid,
    output logic                             s_wready,
    output logic [1:0]                       s_bresp,
    output logic                             s_bvalid,
    input  logic                             s_bready,
    // master read address / data
    input  logic [ADDR_WIDTH-1:0]            s_araddr,
    input  logic [2:0]                       s_arprot,
    input  logic                             s_arvalid,
    output logic                             s_arready,
    output logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rvalid,
    input  logic                             s_rready,
    // slave write side
    output logic [SLAVE_ADDR_BITS-1:0]       m_awaddr,
    output logic [2:0]                       m_awprot,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [STRB_WIDTH-1:0]            m_wstrb,
    output logic [NUM_SLAVES-1:0]            m_awvalid,
    input  logic [NUM_SLAVES-1:0]            m_awready,
    output logic [NUM_SLAVES-1:0]            m_wvalid,
    input  logic [NUM_SLAVES-1:0]            m_wready,
    input  logic [NUM_SLAVES-1:0]            m_bvalid,
    output logic [NUM_SLAVES-1:0]            m_bready,
    input  logic [2*NUM_SLAVES-1:0]          m_bresp,
    // slave read side
    output logic [SLAVE_ADDR_BITS-1:0]       m_araddr,
    output logic [2:0]                       m_arprot,
    output logic [NUM_SLAVES-1:0]            m_arvalid,
    input  logic [NUM_SLAVES-1:0]            m_arready,
    input  logic [NUM_SLAVES-1:0]            m_rvalid,
    output logic [NUM_SLAVES-1:0]            m_rready,
    input  logic [DATA_WIDTH*NUM_SLAVES-1:0] m_rdata,
    input  logic [2*NUM_SLAVES-1:0]          m_rresp
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WIN_W = ADDR_WIDTH - SLAVE_ADDR_BITS;
    localparam logic [WIN_W-1:0] BASE_PAGE = BASE_ADDR[ADDR_WIDTH-1:SLAVE_ADDR_BITS];
    localparam logic [WIN_W-1:0] NUM_WIN   = WIN_W'(NUM_SLAVES);
    localparam logic [1:0]       RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} r_state_t;

    typedef struct packed {
        logic             hit;
        logic [SEL_W-1:0] sel;
    } dec_t;

    // Base is window-aligned, so only the page number above the offset bits matters.
    function automatic dec_t decode(input logic [WIN_W-1:0] page);
        dec_t             d;
        logic [WIN_W-1:0] idx;
        idx   = page - BASE_PAGE;
        d.hit = (page >= BASE_PAGE) && (idx < NUM_WIN);
        d.sel = idx[SEL_W-1:0];
        return d;
    endfunction

    function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_SLAVES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SLAVES; i++) v[i] = (i[SEL_W-1:0] == sel);
        return v;
    endfunction

    // ---------------------------------------------------------------- write path
    w_state_t               r_wstate, w_wstate_nxt;
    logic                   r_aw_captured, r_w_captured;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [2:0]             r_awprot;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic [NUM_SLAVES-1:0]  r_m_awvalid, r_m_wvalid;
    dec_t                   w_wdec;
    logic [NUM_SLAVES-1:0]  w_wsel_oh;
    logic                   w_aw_pend, w_w_pend;
    logic                   w_sel_bvalid;
    logic [1:0]             w_sel_bresp;

    assign w_wdec    = decode(r_awaddr[ADDR_WIDTH-1:SLAVE_ADDR_BITS]);
    assign w_wsel_oh = onehot(w_wdec.sel);
    assign w_aw_pend = |(r_m_awvalid & ~m_awready);
    assign w_w_pend  = |(r_m_wvalid & ~m_wready);

    always_comb begin
        w_sel_bvalid = 1'b0;
        w_sel_bresp  = 2'b00;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i[SEL_W-1:0] == w_wdec.sel) begin
                w_sel_bvalid = m_bvalid[i];
                w_sel_bresp  = m_bresp[2*i +: 2];
            end
        end
    end

    // NOTE: asynchronous reset sits in the sensitivity list; state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_wstate_nxt = r_wstate;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        s_bresp      = 2'b00;
        m_bready     = '0;
        case (r_wstate)
            W_IDLE: begin
                s_awready = !r_aw_captured;
                s_wready  = !r_w_captured;
                if (r_aw_captured && r_w_captured)
                    w_wstate_nxt = w_wdec.hit ? W_FWD : W_ERR;
            end
            W_FWD: begin
                if (!w_aw_pend && !w_w_pend) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_bvalid = w_sel_bvalid;
                s_bresp  = w_sel_bresp;
                m_bready = s_bready ? w_wsel_oh : '0;
                if (w_sel_bvalid && s_bready) w_wstate_nxt = W_IDLE;
            end
            W_ERR: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_DECERR;
                if (s_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_captured <= 1'b0;
            r_w_captured  <= 1'b0;
            r_awaddr      <= '0;
            r_awprot      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_m_awvalid   <= '0;
            r_m_wvalid    <= '0;
        end else begin
            if (s_awvalid && s_awready) begin
                r_aw_captured <= 1'b1;
                r_awaddr      <= s_awaddr;
                r_awprot      <= s_awprot;
            end
            if (s_wvalid && s_wready) begin
                r_w_captured <= 1'b1;
                r_wdata      <= s_wdata;
                r_wstrb      <= s_wstrb;
            end
            if (r_wstate == W_IDLE && w_wstate_nxt != W_IDLE) begin
                r_aw_captured <= 1'b0;
                r_w_captured  <= 1'b0;
            end
            // Each slave strobe drops independently on its own ready.
            if (r_wstate == W_IDLE && w_wstate_nxt == W_FWD) begin
                r_m_awvalid <= w_wsel_oh;
                r_m_wvalid  <= w_wsel_oh;
            end else begin
                r_m_awvalid <= r_m_awvalid & ~m_awready;
                r_m_wvalid  <= r_m_wvalid & ~m_wready;
            end
        end
    end

    assign m_awaddr  = r_awaddr[SLAVE_ADDR_BITS-1:0];
    assign m_awprot  = r_awprot;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_awvalid = r_m_awvalid;
    assign m_wvalid  = r_m_wvalid;

    // ----------------------------------------------------------------- read path
    r_state_t               r_rstate, w_rstate_nxt;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [2:0]             r_arprot;
    logic [NUM_SLAVES-1:0]  r_m_arvalid;
    dec_t                   w_ar_in_dec, w_rdec;
    logic [NUM_SLAVES-1:0]  w_rsel_oh;
    logic                   w_sel_rvalid;
    logic [DATA_WIDTH-1:0]  w_sel_rdata;
    logic [1:0]             w_sel_rresp;

    // Incoming address is decoded at capture so the slave sees arvalid the very next cycle.
    assign w_ar_in_dec = decode(s_araddr[ADDR_WIDTH-1:SLAVE_ADDR_BITS]);
    assign w_rdec      = decode(r_araddr[ADDR_WIDTH-1:SLAVE_ADDR_BITS]);
    assign w_rsel_oh   = onehot(w_rdec.sel);

    always_comb begin
        w_sel_rvalid = 1'b0;
        w_sel_rdata  = '0;
        w_sel_rresp  = 2'b00;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i[SEL_W-1:0] == w_rdec.sel) begin
                w_sel_rvalid = m_rvalid[i];
                w_sel_rdata  = m_rdata[DATA_WIDTH*i +: DATA_WIDTH];
                w_sel_rresp  = m_rresp[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        s_arready    = 1'b0;
        s_rvalid     = 1'b0;
        s_rdata      = '0;
        s_rresp      = 2'b00;
        m_rready     = '0;
        case (r_rstate)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) w_rstate_nxt = w_ar_in_dec.hit ? R_FWD : R_ERR;
            end
            R_FWD: begin
                if (|(r_m_arvalid & m_arready)) w_rstate_nxt = R_RESP;
            end
            R_RESP: begin
                s_rvalid = w_sel_rvalid;
                s_rdata  = w_sel_rdata;
                s_rresp  = w_sel_rresp;
                m_rready = s_rready ? w_rsel_oh : '0;
                if (w_sel_rvalid && s_rready) w_rstate_nxt = R_IDLE;
            end
            R_ERR: begin
                s_rvalid = 1'b1;
                s_rresp  = RESP_DECERR;
                if (s_rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_araddr    <= '0;
            r_arprot    <= '0;
            r_m_arvalid <= '0;
        end else if (s_arvalid && s_arready) begin
            r_araddr    <= s_araddr;
            r_arprot    <= s_arprot;
            r_m_arvalid <= w_ar_in_dec.hit ? onehot(w_ar_in_dec.sel) : '0;
        end else begin
            r_m_arvalid <= r_m_arvalid & ~m_arready;
        end
    end

    assign m_araddr  = r_araddr[SLAVE_ADDR_BITS-1:0];
    assign m_arprot  = r_arprot;
    assign m_arvalid = r_m_arvalid;

endmodule
